matmul_core: RTL
================

MATMUL_CORE -- requirements
Module: matmul_core

Interface
REQ-001 The block SHALL have one clock, Clk, and a synchronous, active-high reset, RST; all state SHALL update on the rising edge of Clk only.
REQ-002 The block SHALL have these parameters (name, default, meaning):
  DW, 8, data width of matrix elements (unsigned).
  AW, 8, memory address width; also the width of the dimension inputs.
  CORES, 1, number of cores sharing the row space.
  CORE_ID, 0, this core's index, range 0..CORES-1.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
  Clk  in  1  clock.
  RST  in  1  synchronous active-high reset.
  start  in  1  job request, sampled in IDLE only.
  sat_en  in  1  1 = saturate stored result, 0 = wrap; latched at start.
  dim_m, dim_k, dim_n  in  AW  matrix dimensions: A is MxK, B is KxN, C is MxN; latched at start.
  a_base, b_base, c_base  in  AW  base addresses, latched at start.
  mem_addr  out  AW  synchronous-RAM address.
  mem_wdata  out  DW  write data.
  mem_we  out  1  write enable.
  mem_rdata  in  DW  read data, valid one cycle after its address.
  busy  out  1  job in progress.
  done  out  1  one-cycle completion pulse.

Function
REQ-004 FSM states SHALL be IDLE, INIT, RDA, RDB, MAC, STORE, DONE.
REQ-005 IDLE with start=1 SHALL latch the configuration and go to INIT; start in any other state SHALL be ignored.
REQ-006 INIT SHALL set i=CORE_ID, j=0, k=0, acc=0; if dim_m, dim_k or dim_n is 0, or CORE_ID >= dim_m, it SHALL go to DONE; otherwise it SHALL go to RDA.
REQ-007 RDA SHALL drive mem_addr = a_base + i*dim_k + k.
REQ-008 RDB SHALL drive mem_addr = b_base + k*dim_n + j and SHALL capture mem_rdata as the A operand.
REQ-009 MAC SHALL do acc += A_operand * mem_rdata and then k++. If the new k < dim_k it SHALL go to RDA; otherwise it SHALL go to STORE.
REQ-010 STORE SHALL drive mem_addr = c_base + i*dim_n + j, mem_wdata = result, and mem_we=1 for exactly one cycle.
REQ-011 After STORE the block SHALL clear acc and k and then step indices:
  - j++; if j == dim_n, then j=0 and i += CORES.
  - If i >= dim_m, go to DONE; otherwise go to RDA.
REQ-012 DONE SHALL assert done=1 for one cycle with busy=0, then go to IDLE.
REQ-013 busy SHALL be 1 in INIT, RDA, RDB, MAC and STORE, and 0 otherwise.
REQ-014 Latency: busy SHALL last exactly 1 + R*dim_n*(3*dim_k+1) cycles, where R is the number of rows i in {CORE_ID, CORE_ID+CORES, ...} with i < dim_m.
REQ-015 Arithmetic:
  - Products SHALL be 2*DW bits wide, unsigned.
  - acc SHALL be 2*DW+AW bits wide and SHALL never overflow.
  - Address arithmetic SHALL wrap modulo 2^AW.
REQ-016 result SHALL be acc[DW-1:0] when sat_en=0. When sat_en=1 it SHALL be min(acc, 2^DW-1).
REQ-017 mem_we SHALL be 0 in every state except STORE. mem_addr and mem_wdata SHALL be 0 in IDLE, INIT and DONE.
REQ-018 Configuration input changes while busy SHALL have no effect on the running job.

Reset
REQ-019 RST=1 SHALL force these values on the next edge: state=IDLE, busy=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0, acc=0, and all indices and latched config cleared.
REQ-020 RST during a job SHALL abort the job with no further write and no done pulse. RST SHALL take priority over start.

Structure
REQ-021 A shared package matmul_pkg SHALL hold the state encoding, the accumulator-width expression and the default parameter values.
REQ-022 The multiply-accumulate and saturation logic SHALL be one sub-module, mac_unit, with inputs clear, enable, a, b and sat_en, and outputs acc and result.
REQ-023 Row-stride partitioning SHALL make CORES instances with distinct CORE_IDs, sharing one memory through an external arbiter, write disjoint C rows.

Verification
REQ-024 Identity test, DW=8, 2x2x2: A=I, B=[[3,4],[5,6]], start.
  - C SHALL be [[3,4],[5,6]].
  - busy SHALL last 29 cycles.
  - done SHALL pulse once.
REQ-025 Wrap vs saturate, 1x1x1: A=200, B=200.
  - sat_en=0 SHALL store 0x40.
  - sat_en=1 SHALL store 0xFF.
REQ-026 Zero dimension: dim_k=0 -> busy SHALL last 1 cycle, then done pulses, with no mem_we.
REQ-027 Two cores, CORES=2 with CORE_ID 0 and 1, 3x1x1 with all elements 2.
  - Core 0 SHALL write rows 0 and 2; core 1 SHALL write row 1.
  - Every C element SHALL be 4.
  - CORE_ID=5 with dim_m=3 SHALL give busy=1 cycle and done.
REQ-028 Mid-job reset and ignored start.
  - RST in the 5th MAC cycle SHALL leave IDLE next cycle with no done and no further writes.
  - A start pulse while busy SHALL be ignored.
REQ-029 Address wrap: a_base=0xFE, dim_k=4 -> A reads SHALL hit 0xFE, 0xFF, 0x00, 0x01.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and defaults for the matmul core: state encoding, default
// parameter values and the accumulator width rule.
package matmul_pkg;

  localparam int unsigned DEF_DW      = 8;
  localparam int unsigned DEF_AW      = 8;
  localparam int unsigned DEF_CORES   = 1;
  localparam int unsigned DEF_CORE_ID = 0;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RDA,
    RDB,
    MAC,
    STORE,
    DONE
  } state_e;

  // Product is 2*DW bits; AW extra bits absorb up to 2^AW-1 summed products.
  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned aw);
    return 2 * dw + aw;
  endfunction

endpackage

// File: rtl/matmul_core_mac_unit.sv
// Multiply-accumulate with optional saturation of the stored result.
// clear has priority over enable; result follows the registered accumulator.
module mac_unit
  import matmul_pkg::*;
#(
  parameter int unsigned DW = DEF_DW,
  parameter int unsigned AW = DEF_AW
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          enable,
  input  logic [DW-1:0]                 a,
  input  logic [DW-1:0]                 b,
  input  logic                          sat_en,
  output logic [acc_width(DW, AW)-1:0]  acc,
  output logic [DW-1:0]                 result
);

  localparam int unsigned ACC_W = acc_width(DW, AW);
  localparam int unsigned PW    = 2 * DW;

  logic [PW-1:0]    prod;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;

  always_comb begin
    prod  = PW'(a) * PW'(b);
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (enable) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

  // Saturate to all-ones whenever any bit above the stored width is set.
  always_comb begin
    result = acc_q[DW-1:0];
    if (sat_en && (acc_q[ACC_W-1:DW] != '0)) begin
      result = '1;
    end
  end

endmodule

// File: rtl/matmul_core.sv
// Row-strided matrix multiply C = A*B over a single synchronous RAM port.
// Processes rows CORE_ID, CORE_ID+CORES, ... so several cores split the rows.
module matmul_core
  import matmul_pkg::*;
#(
  parameter int unsigned DW      = DEF_DW,
  parameter int unsigned AW      = DEF_AW,
  parameter int unsigned CORES   = DEF_CORES,
  parameter int unsigned CORE_ID = DEF_CORE_ID
) (
  input  logic          Clk,
  input  logic          RST,
  input  logic          start,
  input  logic          sat_en,
  input  logic [AW-1:0] dim_m,
  input  logic [AW-1:0] dim_k,
  input  logic [AW-1:0] dim_n,
  input  logic [AW-1:0] a_base,
  input  logic [AW-1:0] b_base,
  input  logic [AW-1:0] c_base,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          done
);

  localparam int unsigned ACC_W  = acc_width(DW, AW);
  localparam logic [AW:0] STRIDE = (AW + 1)'(CORES);

  state_e        state_q, state_d;
  logic [AW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic [AW-1:0] dm_q, dm_d, dk_q, dk_d, dn_q, dn_d;
  logic [AW-1:0] ab_q, ab_d, bb_q, bb_d, cb_q, cb_d;
  logic          sat_q, sat_d;
  logic [DW-1:0] opa_q, opa_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [AW:0]   i_step;

  logic             mac_clear;
  logic             mac_enable;
  logic [ACC_W-1:0] acc_unused;
  logic [DW-1:0]    mac_result;

  // Next state, index stepping and config latch.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    dm_d    = dm_q;
    dk_d    = dk_q;
    dn_d    = dn_q;
    ab_d    = ab_q;
    bb_d    = bb_q;
    cb_d    = cb_q;
    sat_d   = sat_q;
    opa_d   = opa_q;
    i_step  = {1'b0, i_q} + STRIDE;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          dm_d    = dim_m;
          dk_d    = dim_k;
          dn_d    = dim_n;
          ab_d    = a_base;
          bb_d    = b_base;
          cb_d    = c_base;
          sat_d   = sat_en;
          state_d = INIT;
        end
      end
      INIT: begin
        i_d = AW'(CORE_ID);
        j_d = '0;
        k_d = '0;
        if ((dm_q == '0) || (dk_q == '0) || (dn_q == '0) || (CORE_ID >= 32'(dm_q))) begin
          state_d = DONE;
        end else begin
          state_d = RDA;
        end
      end
      RDA: begin
        state_d = RDB;
      end
      RDB: begin
        opa_d   = mem_rdata;
        state_d = MAC;
      end
      MAC: begin
        k_d     = k_q + AW'(1);
        state_d = (k_d < dk_q) ? RDA : STORE;
      end
      STORE: begin
        k_d     = '0;
        j_d     = j_q + AW'(1);
        state_d = RDA;
        if (j_d == dn_q) begin
          j_d = '0;
          i_d = i_step[AW-1:0];
          if (i_step >= {1'b0, dm_q}) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    addr_d = '0;
    unique case (state_d)
      RDA:     addr_d = ab_q + i_d * dk_q + k_d;
      RDB:     addr_d = bb_q + k_d * dn_q + j_d;
      STORE:   addr_d = cb_q + i_d * dn_q + j_d;
      default: addr_d = '0;
    endcase
    we_d   = (state_d == STORE);
    done_d = (state_d == DONE);
    busy_d = (state_d == INIT) || (state_d == RDA) || (state_d == RDB) ||
             (state_d == MAC) || (state_d == STORE);
  end

  always_ff @(posedge Clk) begin
    if (RST) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      dm_q    <= '0;
      dk_q    <= '0;
      dn_q    <= '0;
      ab_q    <= '0;
      bb_q    <= '0;
      cb_q    <= '0;
      sat_q   <= 1'b0;
      opa_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      dm_q    <= dm_d;
      dk_q    <= dk_d;
      dn_q    <= dn_d;
      ab_q    <= ab_d;
      bb_q    <= bb_d;
      cb_q    <= cb_d;
      sat_q   <= sat_d;
      opa_q   <= opa_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign mac_clear  = (state_q == INIT) || (state_q == STORE);
  assign mac_enable = (state_q == MAC);

  mac_unit #(
    .DW(DW),
    .AW(AW)
  ) u_mac (
    .clk    (Clk),
    .rst    (RST),
    .clear  (mac_clear),
    .enable (mac_enable),
    .a      (opa_q),
    .b      (mem_rdata),
    .sat_en (sat_q),
    .acc    (acc_unused),
    .result (mac_result)
  );

  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  // The accumulator is final during STORE, so gating the result is enough.
  assign mem_wdata = we_q ? mac_result : '0;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
